poly_voice_alloc: RTL and testbench

//  N-voice MIDI note allocator replacing the single GATE/LAST_NOTE register pair of the mono synth.

---
 rtl/poly_voice_alloc_pkg.sv | 10 +
 rtl/poly_voice_alloc_if.sv | 20 ++
 rtl/poly_voice_alloc_voice_pick.sv | 29 ++
 rtl/poly_voice_alloc.sv | 106 ++++++++++
 tb/tb_poly_voice_alloc.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/poly_voice_alloc_pkg.sv
// poly_voice_alloc_pkg: shared MIDI widths, voice limits, allocation action type and index width helper
package poly_voice_alloc_pkg;
  localparam int NOTE_DW = 7;
  localparam int VEL_DW = 7;
  localparam int MAX_VOICES = 16;
  typedef enum logic [1:0] {ACT_NONE, ACT_RETRIG, ACT_FREE, ACT_STEAL} act_e;
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/poly_voice_alloc_if.sv
// poly_voice_alloc_if: note strobe inputs and per-voice outputs of the voice allocator
interface poly_voice_alloc_if
  import poly_voice_alloc_pkg::*;
#(parameter int VOICES = 4, parameter int NOTE_W = NOTE_DW);
  logic note_on;
  logic note_off;
  logic sustain;
  logic [NOTE_W-1:0] note;
  logic [NOTE_W-1:0] velocity;
  logic [VOICES-1:0] gate;
  logic [VOICES-1:0] trig;
  logic [VOICES*NOTE_W-1:0] voice_note;
  logic [VOICES*NOTE_W-1:0] voice_vel;
  logic steal;
  logic all_busy;
  modport master(output note_on, note_off, sustain, note, velocity,
                 input gate, trig, voice_note, voice_vel, steal, all_busy);
  modport slave(input note_on, note_off, sustain, note, velocity,
                output gate, trig, voice_note, voice_vel, steal, all_busy);
endinterface

// File: rtl/poly_voice_alloc_voice_pick.sv
// poly_voice_alloc_voice_pick: arg-max of ages over a voice mask, lowest index wins ties
module poly_voice_alloc_voice_pick #(
  parameter int N = 4,
  parameter int AW = 8,
  parameter int IW = 2
) (
  input  logic [N-1:0][AW-1:0] age_i,
  input  logic [N-1:0]         mask_i,
  output logic [IW-1:0]        idx_o,
  output logic                 valid_o
);
  logic [AW-1:0] best;
  logic [IW-1:0] idx;
  logic found;
  always_comb begin
    best = '0;
    idx = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (mask_i[i] && (!found || age_i[i] > best)) begin
        best = age_i[i];
        idx = IW'(i);
        found = 1'b1;
      end
    end
  end
  assign idx_o = idx;
  assign valid_o = found;
endmodule

// File: rtl/poly_voice_alloc.sv
// poly_voice_alloc: N-voice MIDI note allocator with oldest-voice stealing.
// Optional sustain pedal support when SUSTAIN_PEDAL_EN is defined.
module poly_voice_alloc
  import poly_voice_alloc_pkg::*;
#(
  parameter int VOICES = 4,
  parameter int NOTE_W = NOTE_DW,
  parameter int AGE_W = 8
) (
  input logic clk,
  input logic rst_n,
  poly_voice_alloc_if.slave bus
);
  localparam int IW = idx_w(VOICES);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  logic [VOICES-1:0] gate_q, gate_d, trig_q, trig_d, match, gate1, hit;
  logic [VOICES-1:0][NOTE_W-1:0] note_q, note_d, vel_q, vel_d;
  logic [VOICES-1:0][AGE_W-1:0] age_q, age_d;
  logic steal_q, steal_d, busy_q, off, on, free_v, act_v;
  logic [IW-1:0] free_idx, act_idx, hit_idx, sel;
  act_e act;
`ifdef SUSTAIN_PEDAL_EN
  logic [VOICES-1:0] sus_q, sus_d, sus1;
  logic sus_prev_q, rel;
`else
  logic unused_sustain;
  assign unused_sustain = bus.sustain;
`endif
  poly_voice_alloc_voice_pick #(.N(VOICES), .AW(AGE_W), .IW(IW)) u_pick_free (
    .age_i(age_q), .mask_i(~gate1), .idx_o(free_idx), .valid_o(free_v)
  );
  poly_voice_alloc_voice_pick #(.N(VOICES), .AW(AGE_W), .IW(IW)) u_pick_act (
    .age_i(age_q), .mask_i(gate1), .idx_o(act_idx), .valid_o(act_v)
  );
  // note_off is resolved first so a same-cycle note_on sees the released voices
  always_comb begin
    off = bus.note_off | (bus.note_on & ~|bus.velocity);
    on = bus.note_on & |bus.velocity;
    for (int i = 0; i < VOICES; i++) match[i] = gate_q[i] & (note_q[i] == bus.note);
`ifdef SUSTAIN_PEDAL_EN
    rel = sus_prev_q & ~bus.sustain;
    gate1 = gate_q & ~(rel ? sus_q : '0) & ~((off & ~bus.sustain) ? match : '0);
    sus1 = (rel ? '0 : sus_q) | ((off & bus.sustain) ? match : '0);
`else
    gate1 = gate_q & ~(off ? match : '0);
`endif
    for (int i = 0; i < VOICES; i++) hit[i] = gate1[i] & (note_q[i] == bus.note);
    hit_idx = '0;
    for (int i = VOICES - 1; i >= 0; i--) if (hit[i]) hit_idx = IW'(i);
    act = !on ? ACT_NONE : |hit ? ACT_RETRIG : free_v ? ACT_FREE : act_v ? ACT_STEAL : ACT_NONE;
    sel = (act == ACT_RETRIG) ? hit_idx : (act == ACT_FREE) ? free_idx : act_idx;
    gate_d = gate1;
    note_d = note_q;
    vel_d = vel_q;
    age_d = age_q;
    trig_d = '0;
`ifdef SUSTAIN_PEDAL_EN
    sus_d = sus1;
`endif
    if (act != ACT_NONE) begin
      for (int i = 0; i < VOICES; i++) age_d[i] = (age_q[i] == AGE_MAX) ? AGE_MAX : age_q[i] + 1'b1;
      age_d[sel] = '0;
      gate_d[sel] = 1'b1;
      note_d[sel] = bus.note;
      vel_d[sel] = bus.velocity;
      trig_d[sel] = 1'b1;
`ifdef SUSTAIN_PEDAL_EN
      sus_d[sel] = 1'b0;
`endif
    end
    steal_d = (act == ACT_STEAL);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q <= '0;
      trig_q <= '0;
      note_q <= '0;
      vel_q <= '0;
      age_q <= {VOICES{AGE_MAX}};
      steal_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef SUSTAIN_PEDAL_EN
      sus_q <= '0;
      sus_prev_q <= 1'b0;
`endif
    end else begin
      gate_q <= gate_d;
      trig_q <= trig_d;
      note_q <= note_d;
      vel_q <= vel_d;
      age_q <= age_d;
      steal_q <= steal_d;
      busy_q <= &gate_d;
`ifdef SUSTAIN_PEDAL_EN
      sus_q <= sus_d;
      sus_prev_q <= bus.sustain;
`endif
    end
  end
  assign bus.gate = gate_q;
  assign bus.trig = trig_q;
  assign bus.voice_note = note_q;
  assign bus.voice_vel = vel_q;
  assign bus.steal = steal_q;
  assign bus.all_busy = busy_q;
endmodule

// File: tb/tb_poly_voice_alloc.sv
// tb_poly_voice_alloc: randomized scoreboard bench against a voice-list reference model
module tb_poly_voice_alloc;
  localparam int V = 4;
  localparam int NW = 7;
  localparam int AW = 3;
  localparam int AMAX = (1 << AW) - 1;
  typedef struct packed {
    logic [V-1:0] gate;
    logic [V-1:0] trig;
    logic [V*NW-1:0] vn;
    logic [V*NW-1:0] vv;
    logic steal;
    logic busy;
  } out_t;
  typedef struct {
    bit g;
    bit s;
    int n;
    int v;
    int age;
  } voice_t;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int errors = 0;
  out_t exp_q[$];
  voice_t m[V];
  bit m_trig[V];
  bit m_steal;
  bit m_prev_sus;
  poly_voice_alloc_if #(.VOICES(V), .NOTE_W(NW)) bus ();
  poly_voice_alloc #(.VOICES(V), .NOTE_W(NW), .AGE_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic out_t dut_out();
    return '{bus.gate, bus.trig, bus.voice_note, bus.voice_vel, bus.steal, bus.all_busy};
  endfunction
  function automatic out_t model_out();
    out_t o;
    o = '0;
    for (int i = 0; i < V; i++) begin
      o.gate[i] = m[i].g;
      o.trig[i] = m_trig[i];
      o.vn[i*NW +: NW] = NW'(m[i].n);
      o.vv[i*NW +: NW] = NW'(m[i].v);
    end
    o.steal = m_steal;
    o.busy = &o.gate;
    return o;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < V; i++) begin
      m[i] = '{0, 0, 0, 0, AMAX};
      m_trig[i] = 0;
    end
    m_steal = 0;
    m_prev_sus = 0;
  endtask
  // Reference: release pass, then allocation by oldest free voice, else oldest held voice
  task automatic model_step(input bit on, input bit off, input int n, input int v, input bit sus);
    bit offx;
    int t;
    offx = off || (on && v == 0);
    m_steal = 0;
    for (int i = 0; i < V; i++) m_trig[i] = 0;
`ifdef SUSTAIN_PEDAL_EN
    if (m_prev_sus && !sus)
      for (int i = 0; i < V; i++) if (m[i].s) begin m[i].g = 0; m[i].s = 0; end
    m_prev_sus = sus;
`endif
    if (offx)
      for (int i = 0; i < V; i++)
        if (m[i].g && m[i].n == n) begin
`ifdef SUSTAIN_PEDAL_EN
          if (sus) m[i].s = 1; else m[i].g = 0;
`else
          m[i].g = 0;
`endif
        end
    if (!(on && v != 0)) return;
    t = -1;
    for (int i = 0; i < V; i++) if (t < 0 && m[i].g && m[i].n == n) t = i;
    if (t < 0) for (int i = 0; i < V; i++) if (!m[i].g && (t < 0 || m[i].age > m[t].age)) t = i;
    if (t < 0) begin
      m_steal = 1;
      for (int i = 0; i < V; i++) if (t < 0 || m[i].age > m[t].age) t = i;
    end
    for (int i = 0; i < V; i++) m[i].age = (i == t) ? 0 : (m[i].age >= AMAX ? AMAX : m[i].age + 1);
    m[t].g = 1;
    m[t].s = 0;
    m[t].n = n;
    m[t].v = v;
    m_trig[t] = 1;
  endtask
  task automatic step(input bit on, input bit off, input int n, input int v, input bit sus);
    @(negedge clk);
    bus.note_on = on;
    bus.note_off = off;
    bus.note = NW'(n);
    bus.velocity = NW'(v);
    bus.sustain = sus;
    model_step(on, off, n, v, sus);
    exp_q.push_back(model_out());
  endtask
  task automatic idle(input bit sus);
    step(0, 0, 0, 0, sus);
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    bus.note_on = 0;
    bus.note_off = 0;
    bus.sustain = 0;
    #2 rst_n = 0;
    #1;
    chk("async_gate", 64'(bus.gate), 0);
    chk("async_busy", 64'(bus.all_busy), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      out_t e, a;
      e = exp_q.pop_front();
      a = dut_out();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard got g=%h t=%h n=%h v=%h s=%b b=%b expected g=%h t=%h n=%h v=%h s=%b b=%b",
                 a.gate, a.trig, a.vn, a.vv, a.steal, a.busy, e.gate, e.trig, e.vn, e.vv, e.steal, e.busy);
      end
    end
  end
  initial begin
    bus.note_on = 0;
    bus.note_off = 0;
    bus.note = 0;
    bus.velocity = 0;
    bus.sustain = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out", 64'(dut_out()), 0);
    rst_n = 1;
    step(1, 0, 60, 100, 0);
    idle(0);
    chk("first_note", 64'(bus.voice_note[0 +: NW]), 60);
    step(1, 0, 62, 90, 0);
    step(1, 0, 64, 80, 0);
    step(1, 0, 65, 70, 0);
    step(1, 0, 67, 60, 0);
    idle(0);
    chk("steal_note", 64'(bus.voice_note[0 +: NW]), 67);
    pulse_reset();
    step(1, 0, 60, 100, 0);
    step(1, 0, 62, 100, 0);
    step(1, 0, 62, 0, 0);
    idle(0);
    chk("vel0_gate", 64'(bus.gate), 4'b0001);
    chk("vel0_note", 64'(bus.voice_note[NW +: NW]), 62);
    pulse_reset();
    step(1, 0, 60, 100, 0);
    step(1, 0, 60, 40, 0);
    idle(0);
    chk("retrig_vel", 64'(bus.voice_vel[0 +: NW]), 40);
    step(1, 1, 60, 50, 0);
    step(0, 1, 99, 0, 0);
`ifdef SUSTAIN_PEDAL_EN
    pulse_reset();
    step(1, 0, 60, 100, 1);
    step(0, 1, 60, 0, 1);
    idle(1);
    chk("sus_hold", 64'(bus.gate), 4'b0001);
    idle(0);
    idle(0);
    chk("sus_release", 64'(bus.gate), 0);
`endif
    pulse_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 70 + i, 20 + i, 0);
    idle(0);
    chk("four_busy", 64'(bus.all_busy), 1);
    pulse_reset();
    step(1, 0, 48, 33, 0);
    idle(0);
    chk("post_reset_voice", 64'(bus.gate), 4'b0001);
    for (int k = 0; k < 600; k++) begin
      int r;
      r = $urandom_range(0, 99);
      step(r < 55, (r >= 40 && r < 75), $urandom_range(60, 68),
           ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127), $urandom_range(0, 3) != 0);
      if (k % 150 == 149) pulse_reset();
    end
    idle(0);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
